// File: rtl/intersect_unit_pkg.sv
// Token encodings and FSM state type shared by the intersect/union joiner.
// Words are 17 bits: bit16 clear means data, set means a control token.
package intersect_unit_pkg;

  localparam logic [16:0] STOP_BASE = 17'h10000;
  localparam logic [16:0] DONE      = 17'h10100;
  localparam logic [16:0] EMPTY     = 17'h10200;

  typedef enum logic [1:0] {
    ST_START,
    ST_JOIN,
    ST_DONE
  } state_t;

  function automatic logic is_done(input logic [16:0] w);
    return w == DONE;
  endfunction

  // Rebuilds S(n) from a stop level so stray upper bits never leak through.
  function automatic logic [16:0] stop_token(input logic [7:0] n);
    return STOP_BASE | {9'd0, n};
  endfunction

endpackage

// File: rtl/joiner_out_reg.sv
// Three-lane registered valid/ready output slice for the joiner.
// Loads a coord/pos/pos triple at once and drains it when downstream accepts.
module joiner_out_reg
  import intersect_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [16:0] in_coord,
  input  logic [16:0] in_pos_0,
  input  logic [16:0] in_pos_1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:0] out_coord,
  output logic [16:0] out_pos_0,
  output logic [16:0] out_pos_1
);

  logic drain;

  assign drain    = out_valid && out_ready;
  assign in_ready = !out_valid || drain;

  // Flush acts as a clear even while the clock enable is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_coord <= '0;
      out_pos_0 <= '0;
      out_pos_1 <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_coord <= '0;
      out_pos_0 <= '0;
      out_pos_1 <= '0;
    end else if (clk_en) begin
      if (in_valid && in_ready) begin
        out_valid <= 1'b1;
        out_coord <= in_coord;
        out_pos_0 <= in_pos_0;
        out_pos_1 <= in_pos_1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/intersect_unit.sv
// Joins two sorted coordinate streams (intersect or union) with their paired
// position streams, emitting one registered coord/pos/pos triple per step.
module intersect_unit
  import intersect_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        flush,
  input  logic        tile_en,
  input  logic        joiner_op,
  input  logic        vector_reduce_mode,
  input  logic [16:0] coord_in_0,
  input  logic        coord_in_0_valid,
  output logic        coord_in_0_ready,
  input  logic [16:0] coord_in_1,
  input  logic        coord_in_1_valid,
  output logic        coord_in_1_ready,
  input  logic [16:0] pos_in_0,
  input  logic        pos_in_0_valid,
  output logic        pos_in_0_ready,
  input  logic [16:0] pos_in_1,
  input  logic        pos_in_1_valid,
  output logic        pos_in_1_ready,
  output logic [16:0] coord_out,
  output logic        coord_out_valid,
  input  logic        coord_out_ready,
  output logic [16:0] pos_out_0,
  output logic        pos_out_0_valid,
  input  logic        pos_out_0_ready,
  output logic [16:0] pos_out_1,
  output logic        pos_out_1_valid,
  input  logic        pos_out_1_ready
);

  state_t      state;
  logic        head_0, head_1, active, space, fire;
  logic        pop_0, pop_1, emit, to_done;
  logic        data_0, data_1, done_0, done_1;
  logic [16:0] fill, emit_coord, emit_pos_0, emit_pos_1;
  logic        reg_valid, reg_ready;

  assign head_0 = coord_in_0_valid && pos_in_0_valid;
  assign head_1 = coord_in_1_valid && pos_in_1_valid;
  assign active = tile_en && clk_en && !flush;
  assign fire   = active && space && (state == ST_JOIN) && head_0 && head_1;

  // Join decision for the current pair of heads; a Done head that is not
  // matched by a Done on the other side behaves like a Stop and is kept.
  always_comb begin
    pop_0      = 1'b0;
    pop_1      = 1'b0;
    emit       = 1'b0;
    to_done    = 1'b0;
    emit_coord = '0;
    emit_pos_0 = '0;
    emit_pos_1 = '0;
    fill       = vector_reduce_mode ? 17'h00000 : EMPTY;
    data_0     = !coord_in_0[16];
    data_1     = !coord_in_1[16];
    done_0     = is_done(coord_in_0);
    done_1     = is_done(coord_in_1);
    if (done_0 && done_1) begin
      pop_0      = 1'b1;
      pop_1      = 1'b1;
      emit       = 1'b1;
      to_done    = 1'b1;
      emit_coord = DONE;
      emit_pos_0 = DONE;
      emit_pos_1 = DONE;
    end else if (data_0 && data_1 && coord_in_0[15:0] == coord_in_1[15:0]) begin
      pop_0      = 1'b1;
      pop_1      = 1'b1;
      emit       = 1'b1;
      emit_coord = coord_in_0;
      emit_pos_0 = pos_in_0;
      emit_pos_1 = pos_in_1;
    end else if (data_0 && (!data_1 || coord_in_0[15:0] < coord_in_1[15:0])) begin
      pop_0      = 1'b1;
      emit       = joiner_op;
      emit_coord = coord_in_0;
      emit_pos_0 = pos_in_0;
      emit_pos_1 = fill;
    end else if (data_1) begin
      pop_1      = 1'b1;
      emit       = joiner_op;
      emit_coord = coord_in_1;
      emit_pos_0 = fill;
      emit_pos_1 = pos_in_1;
    end else begin
      emit = 1'b1;
      if (done_0) begin
        pop_1      = 1'b1;
        emit_coord = stop_token(coord_in_1[7:0]);
      end else if (done_1) begin
        pop_0      = 1'b1;
        emit_coord = stop_token(coord_in_0[7:0]);
      end else begin
        pop_0      = 1'b1;
        pop_1      = 1'b1;
        emit_coord = stop_token(coord_in_0[7:0]);
      end
      emit_pos_0 = emit_coord;
      emit_pos_1 = emit_coord;
    end
  end

  assign coord_in_0_ready = fire && pop_0;
  assign pos_in_0_ready   = fire && pop_0;
  assign coord_in_1_ready = fire && pop_1;
  assign pos_in_1_ready   = fire && pop_1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_START;
    end else if (flush) begin
      state <= ST_START;
    end else if (clk_en) begin
      case (state)
        ST_START: if (tile_en && (head_0 || head_1)) state <= ST_JOIN;
        ST_JOIN:  if (fire && to_done) state <= ST_DONE;
        ST_DONE:  state <= ST_START;
        default:  state <= ST_START;
      endcase
    end
  end

  assign reg_ready = active && coord_out_ready && pos_out_0_ready && pos_out_1_ready;

  joiner_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .flush     (flush),
    .in_valid  (fire && emit),
    .in_ready  (space),
    .in_coord  (emit_coord),
    .in_pos_0  (emit_pos_0),
    .in_pos_1  (emit_pos_1),
    .out_valid (reg_valid),
    .out_ready (reg_ready),
    .out_coord (coord_out),
    .out_pos_0 (pos_out_0),
    .out_pos_1 (pos_out_1)
  );

  // Valids are masked while the tile is off, stalled or being flushed so a
  // held entry can never be taken twice.
  assign coord_out_valid = reg_valid && active;
  assign pos_out_0_valid = reg_valid && active;
  assign pos_out_1_valid = reg_valid && active;

endmodule

// File: tb/tb_intersect_unit.sv
// Scoreboard bench for intersect_unit: expected triples are queued as each
// stream is launched and popped as the DUT emits them.
module tb_intersect_unit;
  import intersect_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, clk_en, flush, tile_en, joiner_op, vector_reduce_mode;
  logic [16:0] coord_in_0, coord_in_1, pos_in_0, pos_in_1;
  logic        coord_in_0_valid, coord_in_1_valid, pos_in_0_valid, pos_in_1_valid;
  logic        coord_in_0_ready, coord_in_1_ready, pos_in_0_ready, pos_in_1_ready;
  logic [16:0] coord_out, pos_out_0, pos_out_1;
  logic        coord_out_valid, pos_out_0_valid, pos_out_1_valid;
  logic        coord_out_ready, pos_out_0_ready, pos_out_1_ready;

  int total = 0;
  int bad   = 0;

  logic [16:0] exp_c[$], exp_p0[$], exp_p1[$];
  logic [16:0] sc0[$], sp0[$], sc1[$], sp1[$];
  logic [16:0] ec[$], ep0[$], ep1[$];

  always #5 clk = ~clk;

  intersect_unit dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
    .joiner_op(joiner_op), .vector_reduce_mode(vector_reduce_mode),
    .coord_in_0(coord_in_0), .coord_in_0_valid(coord_in_0_valid), .coord_in_0_ready(coord_in_0_ready),
    .coord_in_1(coord_in_1), .coord_in_1_valid(coord_in_1_valid), .coord_in_1_ready(coord_in_1_ready),
    .pos_in_0(pos_in_0), .pos_in_0_valid(pos_in_0_valid), .pos_in_0_ready(pos_in_0_ready),
    .pos_in_1(pos_in_1), .pos_in_1_valid(pos_in_1_valid), .pos_in_1_ready(pos_in_1_ready),
    .coord_out(coord_out), .coord_out_valid(coord_out_valid), .coord_out_ready(coord_out_ready),
    .pos_out_0(pos_out_0), .pos_out_0_valid(pos_out_0_valid), .pos_out_0_ready(pos_out_0_ready),
    .pos_out_1(pos_out_1), .pos_out_1_valid(pos_out_1_valid), .pos_out_1_ready(pos_out_1_ready)
  );

  // Both sources and the sink step on the falling edge and sample 1 before the rising edge.
  task automatic src0(input logic [16:0] cs[$], input logic [16:0] ps[$]);
    for (int i = 0; i < cs.size(); i++) begin
      int guard;
      logic took;
      guard = 0;
      took = 1'b0;
      coord_in_0 = cs[i]; pos_in_0 = ps[i];
      coord_in_0_valid = 1'b1; pos_in_0_valid = 1'b1;
      while (!took && guard < 400) begin
        #4;
        took = coord_in_0_ready && pos_in_0_ready;
        @(negedge clk);
        guard++;
      end
      if (!took) begin
        total++; bad++;
        $display("[TB] FAIL src0_pop: word %0d ready=%b required=1", i, coord_in_0_ready);
        break;
      end
    end
    coord_in_0_valid = 1'b0; pos_in_0_valid = 1'b0;
  endtask

  task automatic src1(input logic [16:0] cs[$], input logic [16:0] ps[$]);
    for (int i = 0; i < cs.size(); i++) begin
      int guard;
      logic took;
      guard = 0;
      took = 1'b0;
      coord_in_1 = cs[i]; pos_in_1 = ps[i];
      coord_in_1_valid = 1'b1; pos_in_1_valid = 1'b1;
      while (!took && guard < 400) begin
        #4;
        took = coord_in_1_ready && pos_in_1_ready;
        @(negedge clk);
        guard++;
      end
      if (!took) begin
        total++; bad++;
        $display("[TB] FAIL src1_pop: word %0d ready=%b required=1", i, coord_in_1_ready);
        break;
      end
    end
    coord_in_1_valid = 1'b0; pos_in_1_valid = 1'b0;
  endtask

  task automatic sink(input int n, input int stall_at, input logic tput);
    int got, cyc, first, last, stall_left;
    logic stalled;
    logic [16:0] snap_c, snap_p0, snap_p1, wc, wp0, wp1;
    got = 0; cyc = 0; first = -1; last = -1; stall_left = 0; stalled = 1'b0;
    snap_c = '0; snap_p0 = '0; snap_p1 = '0;
    while (got < n && cyc < 1000) begin
      if (!stalled && got == stall_at && coord_out_valid) begin
        stalled = 1'b1; stall_left = 5;
        snap_c = coord_out; snap_p0 = pos_out_0; snap_p1 = pos_out_1;
      end
      pos_out_1_ready = (stall_left == 0);
      #4;
      if (stall_left > 0) begin
        total++;
        if ({coord_out_valid, coord_out, pos_out_0, pos_out_1, coord_in_0_ready, coord_in_1_ready}
            !== {1'b1, snap_c, snap_p0, snap_p1, 2'b00}) begin
          bad++;
          $display("[TB] FAIL stall_hold: got v=%b %h %h %h rdy=%b%b want v=1 %h %h %h rdy=00",
                   coord_out_valid, coord_out, pos_out_0, pos_out_1, coord_in_0_ready,
                   coord_in_1_ready, snap_c, snap_p0, snap_p1);
        end
        stall_left--;
      end else if (coord_out_valid) begin
        total++;
        if (exp_c.size() == 0) begin
          bad++;
          $display("[TB] FAIL extra_output: got %h %h %h want nothing", coord_out, pos_out_0, pos_out_1);
        end else begin
          wc = exp_c.pop_front(); wp0 = exp_p0.pop_front(); wp1 = exp_p1.pop_front();
          if ({coord_out, pos_out_0, pos_out_1} !== {wc, wp0, wp1}) begin
            bad++;
            $display("[TB] FAIL out_%0d: got %h %h %h want %h %h %h",
                     got, coord_out, pos_out_0, pos_out_1, wc, wp0, wp1);
          end
        end
        total++;
        if ({pos_out_0_valid, pos_out_1_valid} !== 2'b11) begin
          bad++;
          $display("[TB] FAIL lane_valids: got %b%b want 11", pos_out_0_valid, pos_out_1_valid);
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    pos_out_1_ready = 1'b1;
    total++;
    if (got != n) begin
      bad++;
      $display("[TB] FAIL out_count: got %0d want %0d", got, n);
    end
    if (tput && got == n) begin
      total++;
      if (last - first != n - 1) begin
        bad++;
        $display("[TB] FAIL throughput: got %0d cycles want %0d", last - first + 1, n);
      end
    end
  endtask

  task automatic run_stream(input logic op, input logic vrm, input int stall_at,
                            input logic tput, input string name);
    joiner_op = op;
    vector_reduce_mode = vrm;
    exp_c.delete(); exp_p0.delete(); exp_p1.delete();
    foreach (ec[i]) begin
      exp_c.push_back(ec[i]); exp_p0.push_back(ep0[i]); exp_p1.push_back(ep1[i]);
    end
    @(negedge clk);
    fork
      src0(sc0, sp0);
      src1(sc1, sp1);
      sink(ec.size(), stall_at, tput);
    join
    repeat (3) @(negedge clk);
    total++;
    if (coord_out_valid !== 1'b0 || exp_c.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s_tail: valid=%b left=%0d want valid=0 left=0", name, coord_out_valid, exp_c.size());
    end
  endtask

  task automatic load_basic_stim();
    sc0 = '{17'd0, 17'd2, STOP_BASE, DONE};  sp0 = '{17'd10, 17'd20, STOP_BASE, DONE};
    sc1 = '{17'd2, 17'd3, STOP_BASE, DONE};  sp1 = '{17'd5, 17'd7, STOP_BASE, DONE};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({coord_out_valid, pos_out_0_valid, pos_out_1_valid, coord_in_0_ready, coord_in_1_ready,
         pos_in_0_ready, pos_in_1_ready, coord_out, pos_out_0, pos_out_1} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_state: got v=%b%b%b data=%h %h %h want all 0",
               coord_out_valid, pos_out_0_valid, pos_out_1_valid, coord_out, pos_out_0, pos_out_1);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_union_fill_zero();
    load_basic_stim();
    ec  = '{17'd0, 17'd2, 17'd3, STOP_BASE, DONE};
    ep0 = '{17'd10, 17'd20, 17'd0, STOP_BASE, DONE};
    ep1 = '{17'd0, 17'd5, 17'd7, STOP_BASE, DONE};
    run_stream(1'b1, 1'b1, -1, 1'b1, "union_vrm1");
  endtask

  task automatic test_intersect();
    load_basic_stim();
    ec  = '{17'd2, STOP_BASE, DONE};
    ep0 = '{17'd20, STOP_BASE, DONE};
    ep1 = '{17'd5, STOP_BASE, DONE};
    run_stream(1'b0, 1'b0, -1, 1'b0, "intersect");
  endtask

  task automatic test_union_fill_empty();
    load_basic_stim();
    ec  = '{17'd0, 17'd2, 17'd3, STOP_BASE, DONE};
    ep0 = '{17'd10, 17'd20, EMPTY, STOP_BASE, DONE};
    ep1 = '{EMPTY, 17'd5, 17'd7, STOP_BASE, DONE};
    run_stream(1'b1, 1'b0, -1, 1'b1, "union_vrm0");
  endtask

  task automatic test_done_early();
    sc0 = '{17'd1, DONE};                   sp0 = '{17'd11, DONE};
    sc1 = '{17'd1, 17'd4, STOP_BASE, DONE}; sp1 = '{17'd21, 17'd22, STOP_BASE, DONE};
    ec  = '{17'd1, 17'd4, STOP_BASE, DONE};
    ep0 = '{17'd11, 17'd0, STOP_BASE, DONE};
    ep1 = '{17'd21, 17'd22, STOP_BASE, DONE};
    run_stream(1'b1, 1'b1, -1, 1'b0, "done_early");
  endtask

  task automatic test_stall();
    load_basic_stim();
    ec  = '{17'd0, 17'd2, 17'd3, STOP_BASE, DONE};
    ep0 = '{17'd10, 17'd20, 17'd0, STOP_BASE, DONE};
    ep1 = '{17'd0, 17'd5, 17'd7, STOP_BASE, DONE};
    run_stream(1'b1, 1'b1, 2, 1'b0, "stall");
  endtask

  // Random sorted sets merged by a two-pointer model; stop levels differ on purpose.
  task automatic test_back_to_back(input logic op);
    int i, j;
    sc0.delete(); sp0.delete(); sc1.delete(); sp1.delete();
    ec.delete(); ep0.delete(); ep1.delete();
    for (int v = 0; v < 48; v++) begin
      if ($urandom_range(0, 2) == 0) begin sc0.push_back(17'(v)); sp0.push_back({1'b0, 16'($urandom)}); end
      if ($urandom_range(0, 2) == 0) begin sc1.push_back(17'(v)); sp1.push_back({1'b0, 16'($urandom)}); end
    end
    i = 0; j = 0;
    while (i < sc0.size() || j < sc1.size()) begin
      if (i < sc0.size() && j < sc1.size() && sc0[i] == sc1[j]) begin
        ec.push_back(sc0[i]); ep0.push_back(sp0[i]); ep1.push_back(sp1[j]); i++; j++;
      end else if (j >= sc1.size() || (i < sc0.size() && sc0[i] < sc1[j])) begin
        if (op) begin ec.push_back(sc0[i]); ep0.push_back(sp0[i]); ep1.push_back(EMPTY); end
        i++;
      end else begin
        if (op) begin ec.push_back(sc1[j]); ep0.push_back(EMPTY); ep1.push_back(sp1[j]); end
        j++;
      end
    end
    sc0.push_back(STOP_BASE | 17'd5); sp0.push_back(STOP_BASE | 17'd5);
    sc1.push_back(STOP_BASE | 17'd6); sp1.push_back(STOP_BASE | 17'd6);
    sc0.push_back(DONE); sp0.push_back(DONE); sc1.push_back(DONE); sp1.push_back(DONE);
    ec.push_back(STOP_BASE | 17'd5); ep0.push_back(STOP_BASE | 17'd5); ep1.push_back(STOP_BASE | 17'd5);
    ec.push_back(DONE); ep0.push_back(DONE); ep1.push_back(DONE);
    run_stream(op, 1'b0, -1, op, op ? "b2b_union" : "b2b_intersect");
  endtask

  task automatic test_reset_midstream();
    joiner_op = 1'b0;
    coord_in_0 = 17'd1; pos_in_0 = 17'd1; coord_in_1 = 17'd1; pos_in_1 = 17'd1;
    coord_in_0_valid = 1'b1; pos_in_0_valid = 1'b1; coord_in_1_valid = 1'b1; pos_in_1_valid = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (coord_out_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pre_reset_valid: got %b want 1", coord_out_valid);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({coord_out_valid, pos_out_0_valid, pos_out_1_valid, coord_in_0_ready, coord_in_1_ready} !== 5'b0) begin
      bad++;
      $display("[TB] FAIL reset_midstream: got v=%b%b%b rdy=%b%b want 00000", coord_out_valid,
               pos_out_0_valid, pos_out_1_valid, coord_in_0_ready, coord_in_1_ready);
    end
    @(negedge clk);
    coord_in_0_valid = 1'b0; pos_in_0_valid = 1'b0; coord_in_1_valid = 1'b0; pos_in_1_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_union_fill_zero();
  endtask

  task automatic test_flush();
    joiner_op = 1'b0;
    coord_in_0 = 17'd9; pos_in_0 = 17'd1; coord_in_1 = 17'd9; pos_in_1 = 17'd2;
    coord_in_0_valid = 1'b1; pos_in_0_valid = 1'b1; coord_in_1_valid = 1'b1; pos_in_1_valid = 1'b1;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    #4;
    total++;
    if ({coord_out_valid, pos_out_1_valid, coord_in_0_ready, coord_in_1_ready} !== 4'b0) begin
      bad++;
      $display("[TB] FAIL flush_gate: got v=%b%b rdy=%b%b want 0000", coord_out_valid,
               pos_out_1_valid, coord_in_0_ready, coord_in_1_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    total++;
    if ({coord_out_valid, coord_out, pos_out_0, pos_out_1} !== '0) begin
      bad++;
      $display("[TB] FAIL flush_clear: got v=%b %h %h %h want 0", coord_out_valid, coord_out, pos_out_0, pos_out_1);
    end
    @(negedge clk);
    coord_in_0_valid = 1'b0; pos_in_0_valid = 1'b0; coord_in_1_valid = 1'b0; pos_in_1_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tile_off();
    tile_en = 1'b0;
    coord_in_0 = 17'd1; pos_in_0 = 17'd1; coord_in_1 = 17'd1; pos_in_1 = 17'd1;
    coord_in_0_valid = 1'b1; pos_in_0_valid = 1'b1; coord_in_1_valid = 1'b1; pos_in_1_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #4;
      total++;
      if ({coord_out_valid, pos_out_0_valid, pos_out_1_valid, coord_in_0_ready, coord_in_1_ready,
           pos_in_0_ready, pos_in_1_ready} !== 7'b0) begin
        bad++;
        $display("[TB] FAIL tile_off_%0d: got v=%b rdy=%b%b want 0", k, coord_out_valid,
                 coord_in_0_ready, coord_in_1_ready);
      end
    end
    @(negedge clk);
    coord_in_0_valid = 1'b0; pos_in_0_valid = 1'b0; coord_in_1_valid = 1'b0; pos_in_1_valid = 1'b0;
    tile_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; clk_en = 1'b1; flush = 1'b0; tile_en = 1'b1;
    joiner_op = 1'b0; vector_reduce_mode = 1'b0;
    coord_in_0 = '0; coord_in_1 = '0; pos_in_0 = '0; pos_in_1 = '0;
    coord_in_0_valid = 1'b0; coord_in_1_valid = 1'b0; pos_in_0_valid = 1'b0; pos_in_1_valid = 1'b0;
    coord_out_ready = 1'b1; pos_out_0_ready = 1'b1; pos_out_1_ready = 1'b1;
    test_reset();
    test_union_fill_zero();
    test_intersect();
    test_union_fill_empty();
    test_done_early();
    test_stall();
    test_back_to_back(1'b1);
    test_back_to_back(1'b0);
    test_reset_midstream();
    test_flush();
    test_tile_off();
    test_intersect();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/intersect_unit.md
INTERSECT_UNIT -- requirements
Module: intersect_unit

Interface
REQ-001 SHALL have one clock and one reset: asynchronous, active-high.
REQ-002 Port clk, input, 1: rising-edge clock.
REQ-003 Port rst, input, 1: asynchronous active-high reset.
REQ-004 Ports clk_en, input, 1, default 1: when 0, no state or output register changes.
REQ-005 Ports flush, input, 1, default 0: synchronous clear to the reset state.
REQ-006 Ports tile_en, input, 1, default 0: when 0, all readies are 0 and all valids are 0.
REQ-007 Port joiner_op, input, 1, default 0: 1 = union, 0 = intersect.
REQ-008 Port vector_reduce_mode, input, 1, default 0: union fill value select (see REQ-015).
REQ-009 Ports coord_in_0 and coord_in_1, input, 17 each, each with _valid in and _ready out: sorted coordinate streams.
REQ-010 Ports pos_in_0 and pos_in_1, input, 17 each, each with _valid in and _ready out: per-coordinate position or value streams, paired with coord_in_0 and coord_in_1.
REQ-011 Ports coord_out, pos_out_0 and pos_out_1, output, 17 each, each with _valid out and _ready in.

Function
REQ-012 Word format:
- bit16 = 0: data, value in [15:0].
- bit16 = 1: control. Stop token S(n) = 0x10000 | n, with n in 0..255. Done = 0x10100. Empty = 0x10200.
REQ-013 A side's head is present only when its coord and pos valids are both 1; a side's coord and pos are always consumed together.
REQ-014 Both heads data, c0 == c1: emit c0, p0, p1; pop both.
REQ-015 Both heads data, c0 != c1, smaller side X:
- Intersect: pop X; emit nothing.
- Union: emit cX, with pX on X's lane. The other lane gets 0x00000 if vector_reduce_mode = 1, else Empty. Pop X.
REQ-016 One head data, the other Stop:
- Intersect: pop the data side; emit nothing.
- Union: emit per REQ-015 with the data side as X.
REQ-017 Both heads Stop: emit S(n0) on all three outputs; pop both. Level mismatch SHALL still emit S(n0).
REQ-018 Both heads Done: emit Done on all three outputs; pop both; enter DONE.
REQ-019 One head Done, other not Done: pop nothing from the Done side. The other side is processed as if the Done side were Stop.
REQ-020 FSM states:
- START: on the first present head, go to JOIN.
- JOIN: join per REQ-014..REQ-019.
- DONE: one cycle after Done is emitted, return to START.
REQ-021 Outputs are registered; latency is 1 cycle from pop to output valid. All three outputs assert valid together.
REQ-022 The output register advances only when all three output readies are 1. Input ready is high only when the output register is empty or draining that cycle.
REQ-023 While an output valid is high and the output is not accepted, the output data SHALL hold stable.
REQ-024 Simultaneous pop and emit in the same cycle SHALL sustain 1 result per cycle.
REQ-025 Comparison is unsigned on bits [15:0].

Reset
REQ-026 rst or flush SHALL set state to START and clear the output register. All valids, all readies and all data outputs are 0 until the next cycle.
REQ-027 Reset mid-stream discards in-flight tokens; no partial output is emitted.

Structure
REQ-028 A shared package SHALL hold the token constants DONE, EMPTY, STOP_BASE and the FSM state enum.
REQ-029 One sub-module SHALL be used: joiner_out_reg, a 3-lane registered valid/ready slice.

Verification
REQ-030 Union, vector_reduce_mode = 1:
- Stimulus: coords0 = {0, 2, S0, Done}, pos0 = {10, 20, S0, Done}; coords1 = {2, 3, S0, Done}, pos1 = {5, 7, S0, Done}.
- Required coord_out: {0, 2, 3, S0, Done}.
- Required pos0: {10, 20, 0, S0, Done}.
- Required pos1: {0, 5, 7, S0, Done}.
REQ-031 Intersect, same stimulus as REQ-030: coord_out {2, S0, Done}, pos0 {20, S0, Done}, pos1 {5, S0, Done}.
REQ-032 Union, vector_reduce_mode = 0: the missing lane carries 0x10200.
REQ-033 Hold pos_out_1_ready = 0 for 5 cycles mid-stream: outputs stable, no input popped, no token lost or duplicated.
REQ-034 Assert rst mid-stream: all valids drop within the same cycle. A fresh stream afterwards produces correct results.
REQ-035 Run with tile_en = 0: all readies and valids stay 0 for 20 cycles.
